// File: rtl/parity_check_rx_if.sv
// parity_check_rx_if: bit-strobed serial input and received-word outputs of the parity receiver.
interface parity_check_rx_if #(parameter int DATA_WIDTH = 4);
    logic                  bit_en;
    logic                  rx_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  parity_err;
    logic                  frame_err;
    logic                  busy;
    modport master (output bit_en, rx_in, input data_out, data_valid, parity_err, frame_err, busy);
    modport slave  (input bit_en, rx_in, output data_out, data_valid, parity_err, frame_err, busy);
endinterface

// File: rtl/parity_check_rx.sv
// parity_check_rx: deserialises start/data/parity/stop frames and flags parity and framing errors.
module parity_check_rx #(
    parameter int DATA_WIDTH = 4,
    parameter bit ODD_PARITY = 1'b0
) (
    input logic               clk,
    input logic               rst,
    parity_check_rx_if.slave  bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t                state, state_nx;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_bit;
    assign bus.busy = (state != IDLE);
    always_comb begin
        state_nx = state;
        if (bus.bit_en)
            case (state)
                IDLE:    state_nx = bus.rx_in ? IDLE : DATA;
                DATA:    state_nx = (cnt == CW'(DATA_WIDTH - 1)) ? PARITY : DATA;
                PARITY:  state_nx = STOP;
                default: state_nx = IDLE;
            endcase
    end
    // a low stop bit returns to IDLE like any other; it is never taken as a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            shift          <= '0;
            par_bit        <= 1'b0;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            state          <= state_nx;
            bus.data_valid <= 1'b0;
            if (bus.bit_en) begin
                if (state == IDLE)
                    cnt <= '0;
                if (state == DATA) begin
                    shift <= (shift >> 1) | (DATA_WIDTH'(bus.rx_in) << (DATA_WIDTH - 1));
                    cnt   <= cnt + CW'(1);
                end
                if (state == PARITY)
                    par_bit <= bus.rx_in;
                if (state == STOP) begin
                    bus.data_out   <= shift;
                    bus.parity_err <= (^shift) ^ ODD_PARITY ^ par_bit;
                    bus.frame_err  <= ~bus.rx_in;
                    bus.data_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_parity_check_rx.sv
// tb_parity_check_rx: drives even- and odd-parity receivers with the same line and checks each word.
module tb_parity_check_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bit_en = 1'b0;
    logic rx_in = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int pulses_e = 0;
    int pulses_o = 0;
    parity_check_rx_if #(.DATA_WIDTH(4)) ife ();
    parity_check_rx_if #(.DATA_WIDTH(4)) ifo ();
    assign ife.bit_en = bit_en;
    assign ife.rx_in  = rx_in;
    assign ifo.bit_en = bit_en;
    assign ifo.rx_in  = rx_in;
    parity_check_rx #(.DATA_WIDTH(4), .ODD_PARITY(1'b0)) dut_e (.clk(clk), .rst(rst), .bus(ife.slave));
    parity_check_rx #(.DATA_WIDTH(4), .ODD_PARITY(1'b1)) dut_o (.clk(clk), .rst(rst), .bus(ifo.slave));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (ife.data_valid) pulses_e++;
        if (ifo.data_valid) pulses_o++;
    end

    task automatic tick(input logic en, input logic rx);
        bit_en = en;
        rx_in  = rx;
        @(posedge clk);
        #1;
    endtask

    // reference: even receiver flags when p differs from the data XOR, odd one when it matches
    task automatic send(input logic [3:0] d, input logic p, input logic stop, input int gap);
        logic [6:0] bits;
        logic pe_e, pe_o;
        bits = {stop, p, d, 1'b0};
        pe_e = (p != (^d));
        pe_o = (p == (^d));
        for (int i = 0; i < 7; i++) begin
            repeat (gap) tick(1'b0, bits[i]);
            tick(1'b1, bits[i]);
            if (i == 0) begin
                vectors++;
                if (ife.busy !== 1'b1 || ifo.busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL busy_rise got e=%b o=%b want 1", ife.busy, ifo.busy);
                end
            end
        end
        vectors++;
        if (ife.data_valid !== 1'b1 || ife.data_out !== d || ife.parity_err !== pe_e ||
            ife.frame_err !== ~stop || ife.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL even_frame got v=%b d=%h pe=%b fe=%b busy=%b want v=1 d=%h pe=%b fe=%b busy=0",
                     ife.data_valid, ife.data_out, ife.parity_err, ife.frame_err, ife.busy, d, pe_e, ~stop);
        end
        vectors++;
        if (ifo.data_valid !== 1'b1 || ifo.data_out !== d || ifo.parity_err !== pe_o ||
            ifo.frame_err !== ~stop || ifo.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL odd_frame got v=%b d=%h pe=%b fe=%b busy=%b want v=1 d=%h pe=%b fe=%b busy=0",
                     ifo.data_valid, ifo.data_out, ifo.parity_err, ifo.frame_err, ifo.busy, d, pe_o, ~stop);
        end
    endtask

    task automatic check_pulses(input string name, input int want);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        vectors++;
        if (pulses_e !== want || pulses_o !== want) begin
            miscompares++;
            $display("FAIL %s pulses got e=%0d o=%0d want %0d", name, pulses_e, pulses_o, want);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick(1'b0, 1'b1);
        vectors++;
        if (ife.data_out !== 4'h0 || ife.data_valid !== 1'b0 || ife.parity_err !== 1'b0 ||
            ife.frame_err !== 1'b0 || ife.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values got d=%h v=%b pe=%b fe=%b busy=%b want all 0",
                     ife.data_out, ife.data_valid, ife.parity_err, ife.frame_err, ife.busy);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(i[0], 1'b1);
            vectors++;
            if (ife.busy !== 1'b0 || ifo.busy !== 1'b0 || ife.data_out !== 4'h0) begin
                miscompares++;
                $display("FAIL idle_line got busy e=%b o=%b d=%h want 0", ife.busy, ifo.busy, ife.data_out);
            end
        end
        check_pulses("idle", 0);
    endtask

    task automatic test_frame();
        send(4'hB, 1'b1, 1'b1, 0);
        tick(1'b0, 1'b1);
        vectors++;
        if (ife.data_valid !== 1'b0 || ife.data_out !== 4'hB) begin
            miscompares++;
            $display("FAIL valid_width got v=%b d=%h want v=0 d=b", ife.data_valid, ife.data_out);
        end
        check_pulses("frame", 1);
    endtask

    task automatic test_parity_flip();
        send(4'hB, 1'b0, 1'b1, 0);
        check_pulses("parity_flip", 2);
    endtask

    task automatic test_frame_err();
        send(4'h6, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1);
            vectors++;
            if (ife.busy !== 1'b0 || ife.frame_err !== 1'b1 || ife.data_out !== 4'h6) begin
                miscompares++;
                $display("FAIL frame_err_hold got busy=%b fe=%b d=%h want busy=0 fe=1 d=6",
                         ife.busy, ife.frame_err, ife.data_out);
            end
        end
        check_pulses("frame_err", 3);
    endtask

    task automatic test_back_to_back();
        send(4'h5, 1'b0, 1'b1, 2);
        send(4'hA, 1'b0, 1'b1, 2);
        send(4'h3, 1'b0, 1'b1, 0);
        send(4'h8, 1'b1, 1'b1, 0);
        check_pulses("back_to_back", 7);
    endtask

    task automatic test_abort();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        rst = 1'b1;
        #1;
        vectors++;
        if (ife.busy !== 1'b0 || ife.data_out !== 4'h0 || ifo.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_abort got busy=%b d=%h want busy=0 d=0", ife.busy, ife.data_out);
        end
        tick(1'b1, 1'b1);
        rst = 1'b0;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        send(4'hC, 1'b0, 1'b1, 0);
        check_pulses("abort", 8);
    endtask

    task automatic test_random();
        int n;
        n = pulses_e;
        for (int i = 0; i < 40; i++) begin
            logic [3:0] d;
            logic p, s;
            d = 4'($urandom);
            p = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
            s = ($urandom_range(0, 4) != 0);
            send(d, p, s, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) tick(1'b1, 1'b1);
        end
        check_pulses("random", n + 40);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_parity_flip();
        test_frame_err();
        test_back_to_back();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
